// File: rtl/prbs_checker_64.sv
// -----------------------------------------------------------------------------
// prbs_checker_64
//
// Receive-side checker for the 64-bit Fibonacci LFSR bit stream
// (taps 64,63,61,60). It fills a 64-bit history from the incoming stream and
// then searches for LOCK_COUNT consecutive correct predictions. After that it
// locks and lets the local sequence free-run. In the locked state every
// received bit that differs from the prediction counts as one bit error. Lock
// is dropped when LOSS_THRESH errors fall inside one WINDOW-bit window.
//
// Ports:
//   CLK        clock
//   nRST       synchronous, active-low reset
//   in_valid   in_bit is valid this cycle; only valid cycles advance state
//   in_bit     received serial stream bit
//   clear      synchronous clear of err_count (and bit_count); lock unaffected
//   locked     checker is locked to the stream
//   err_pulse  one-cycle pulse per detected bit error
//   err_count  saturating error total since reset or clear
//   bit_count  (only with PRBS_CHECKER_BIT_COUNT_EN) saturating count of bits
//              checked while locked, cleared by clear
//
// Optional feature macro: PRBS_CHECKER_BIT_COUNT_EN adds the bit_count output.
// -----------------------------------------------------------------------------
module prbs_checker_64 #(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW      = 1024,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count
`ifdef PRBS_CHECKER_BIT_COUNT_EN
    ,
    output logic [CNT_W-1:0] bit_count
`endif
);

    localparam int FILL_W  = 6;
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int WIN_W   = $clog2(WINDOW);
    localparam int TH_W    = $clog2(LOSS_THRESH + 1);

    // Feedback taps 64,63,61,60 expressed as history bit positions 63,62,60,59.
    localparam logic [63:0] TAP_MASK = (64'd1 << 63) | (64'd1 << 62) |
                                       (64'd1 << 60) | (64'd1 << 59);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t               state_reg,     state_next;
    logic [63:0]          hist_reg,      hist_next;
    logic [FILL_W-1:0]    fill_cnt_reg,  fill_cnt_next;
    logic [MATCH_W-1:0]   match_cnt_reg, match_cnt_next;
    logic [WIN_W-1:0]     win_cnt_reg,   win_cnt_next;
    logic [TH_W-1:0]      win_err_reg,   win_err_next;
    logic                 locked_reg,    locked_next;
    logic                 err_pulse_reg, err_pulse_next;
    logic [CNT_W-1:0]     err_count_reg, err_count_next;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
    logic [CNT_W-1:0]     bit_count_reg, bit_count_next;
`endif

    logic                 exp_bit;
    logic                 mismatch;
    logic [TH_W-1:0]      win_err_sum;

    // Prediction of the next stream bit from the current history.
    assign exp_bit     = ^(hist_reg & TAP_MASK);
    assign mismatch    = in_bit ^ exp_bit;
    // Error total of the current window including this bit's error, so the
    // threshold is tested before any end-of-window clear.
    assign win_err_sum = win_err_reg + TH_W'(mismatch);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg     <= FILL;
            hist_reg      <= '0;
            fill_cnt_reg  <= '0;
            match_cnt_reg <= '0;
            win_cnt_reg   <= '0;
            win_err_reg   <= '0;
            locked_reg    <= 1'b0;
            err_pulse_reg <= 1'b0;
            err_count_reg <= '0;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
            bit_count_reg <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            hist_reg      <= hist_next;
            fill_cnt_reg  <= fill_cnt_next;
            match_cnt_reg <= match_cnt_next;
            win_cnt_reg   <= win_cnt_next;
            win_err_reg   <= win_err_next;
            locked_reg    <= locked_next;
            err_pulse_reg <= err_pulse_next;
            err_count_reg <= err_count_next;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
            bit_count_reg <= bit_count_next;
`endif
        end
    end

    always_comb begin
        state_next     = state_reg;
        hist_next      = hist_reg;
        fill_cnt_next  = fill_cnt_reg;
        match_cnt_next = match_cnt_reg;
        win_cnt_next   = win_cnt_reg;
        win_err_next   = win_err_reg;
        locked_next    = locked_reg;
        err_pulse_next = 1'b0;
        err_count_next = err_count_reg;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
        bit_count_next = bit_count_reg;
`endif

        if (in_valid) begin
            case (state_reg)
                FILL: begin
                    hist_next = {hist_reg[62:0], in_bit};
                    if (fill_cnt_reg == FILL_W'(63)) begin
                        state_next     = SEARCH;
                        fill_cnt_next  = '0;
                        match_cnt_next = '0;
                    end else begin
                        fill_cnt_next = fill_cnt_reg + FILL_W'(1);
                    end
                end

                SEARCH: begin
                    // The received bit is shifted in so a wrong history
                    // gets flushed and replaced by the live stream.
                    hist_next = {hist_reg[62:0], in_bit};
                    if (!mismatch && (hist_reg != '0)) begin
                        if (match_cnt_reg == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_next     = LOCKED;
                            locked_next    = 1'b1;
                            match_cnt_next = '0;
                            win_cnt_next   = '0;
                            win_err_next   = '0;
                        end else begin
                            match_cnt_next = match_cnt_reg + MATCH_W'(1);
                        end
                    end else begin
                        // An all-zero history predicts zeros forever; it must
                        // never be allowed to accumulate matches.
                        match_cnt_next = '0;
                    end
                end

                LOCKED: begin
                    // Free-run on the prediction so one flipped received bit
                    // produces exactly one error rather than a burst.
                    hist_next = {hist_reg[62:0], exp_bit};
`ifdef PRBS_CHECKER_BIT_COUNT_EN
                    if (bit_count_reg != '1) begin
                        bit_count_next = bit_count_reg + CNT_W'(1);
                    end
`endif
                    if (mismatch) begin
                        err_pulse_next = 1'b1;
                        if (err_count_reg != '1) begin
                            err_count_next = err_count_reg + CNT_W'(1);
                        end
                    end
                    if (win_err_sum == TH_W'(LOSS_THRESH)) begin
                        state_next    = FILL;
                        locked_next   = 1'b0;
                        fill_cnt_next = '0;
                        win_cnt_next  = '0;
                        win_err_next  = '0;
                    end else if (win_cnt_reg == WIN_W'(WINDOW - 1)) begin
                        win_cnt_next = '0;
                        win_err_next = '0;
                    end else begin
                        win_cnt_next = win_cnt_reg + WIN_W'(1);
                        win_err_next = win_err_sum;
                    end
                end

                default: begin
                    state_next  = FILL;
                    locked_next = 1'b0;
                end
            endcase
        end

        // Clear takes priority over a same-cycle increment; err_pulse is
        // deliberately left alone.
        if (clear) begin
            err_count_next = '0;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
            bit_count_next = '0;
`endif
        end
    end

    assign locked    = locked_reg;
    assign err_pulse = err_pulse_reg;
    assign err_count = err_count_reg;
`ifdef PRBS_CHECKER_BIT_COUNT_EN
    assign bit_count = bit_count_reg;
`endif

endmodule
